// File: rtl/mem_req_master_pkg.sv
// Shared encodings for the memory request master: access sizes, completion
// error codes and the controller state type, plus the alignment rule.
package mem_req_master_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ALIGN   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // An op is rejected when its size is illegal or the address is not a
   // multiple of the access size.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
      logic bad;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = addrLo[0];
         SIZE_W:  bad = (addrLo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_req_master_align.sv
// Byte-lane steering between the right-justified core view of data and the
// word-wide memory bus: store mask/data placement and load extraction.
module mem_lane_align
   import mem_req_master_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]         size_i,
   input  logic [1:0]         addr_i,
   input  logic               unsigned_i,
   input  logic [WIDTH-1:0]   wdata_i,
   input  logic [WIDTH-1:0]   rdata_i,
   output logic [WIDTH/8-1:0] mask_o,
   output logic [WIDTH-1:0]   wdata_o,
   output logic [WIDTH-1:0]   rdata_o
);

   localparam int LANES = WIDTH / 8;

   logic [4:0]       sh;
   logic [WIDTH-1:0] raw;

   // Shift store data up into its lanes, pull load data down to bit 0 and
   // extend it according to size and signedness.
   always_comb begin
      sh      = {addr_i, 3'b000};
      wdata_o = wdata_i << sh;
      raw     = rdata_i >> sh;
      mask_o  = '0;
      rdata_o = '0;
      case (size_i)
         SIZE_B: begin
            mask_o  = LANES'(1) << addr_i;
            rdata_o = unsigned_i ? {{(WIDTH-8){1'b0}}, raw[7:0]}
                                 : {{(WIDTH-8){raw[7]}}, raw[7:0]};
         end
         SIZE_H: begin
            mask_o  = LANES'(3) << addr_i;
            rdata_o = unsigned_i ? {{(WIDTH-16){1'b0}}, raw[15:0]}
                                 : {{(WIDTH-16){raw[15]}}, raw[15:0]};
         end
         SIZE_W: begin
            mask_o  = '1;
            rdata_o = raw;
         end
         default: begin
            mask_o  = '0;
            rdata_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/mem_req_master.sv
// Single-outstanding memory request initiator. Accepts a load/store op in
// IDLE, drives one request until the memory answers or the timeout expires,
// then emits a one-cycle completion. All outputs come straight from flops.
module mem_req_master
   import mem_req_master_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic               op_we,
   input  logic [1:0]         op_size,
   input  logic               op_unsigned,
   input  logic [WIDTH-1:0]   op_addr,
   input  logic [WIDTH-1:0]   op_wdata,
   output logic               done_valid,
   output logic [WIDTH-1:0]   done_rdata,
   output logic [1:0]         done_err,
   output logic               req_valid,
   output logic [WIDTH-1:0]   req_addr,
   output logic [WIDTH-1:0]   req_data,
   output logic [WIDTH/8-1:0] req_mask,
   input  logic               resp_valid,
   input  logic [WIDTH-1:0]   resp_data
);

   localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES);

   state_t             state_q, state_d;
   logic               opReady_q, opReady_d;
   logic               reqValid_q, reqValid_d;
   logic [WIDTH-1:0]   reqAddr_q, reqAddr_d;
   logic [WIDTH-1:0]   reqData_q, reqData_d;
   logic [WIDTH/8-1:0] reqMask_q, reqMask_d;
   logic               doneValid_q, doneValid_d;
   logic [WIDTH-1:0]   doneRdata_q, doneRdata_d;
   logic [1:0]         doneErr_q, doneErr_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic [1:0]         addrLo_q, addrLo_d;

   logic [1:0]         alignSize;
   logic [1:0]         alignAddr;
   logic               alignUns;
   logic [WIDTH/8-1:0] alignMask;
   logic [WIDTH-1:0]   alignWdata;
   logic [WIDTH-1:0]   alignRdata;

   // In IDLE the aligner sees the incoming op so req_* can be registered on
   // the accept edge; afterwards it sees the latched op for load extraction.
   always_comb begin
      alignSize = (state_q == IDLE) ? op_size        : size_q;
      alignAddr = (state_q == IDLE) ? op_addr[1:0]   : addrLo_q;
      alignUns  = (state_q == IDLE) ? op_unsigned    : uns_q;
   end

   mem_lane_align #(.WIDTH(WIDTH)) u_align (
      .size_i     (alignSize),
      .addr_i     (alignAddr),
      .unsigned_i (alignUns),
      .wdata_i    (op_wdata),
      .rdata_i    (resp_data),
      .mask_o     (alignMask),
      .wdata_o    (alignWdata),
      .rdata_o    (alignRdata)
   );

   // State and output registers; reset abandons any request in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         opReady_q   <= 1'b1;
         reqValid_q  <= 1'b0;
         reqAddr_q   <= '0;
         reqData_q   <= '0;
         reqMask_q   <= '0;
         doneValid_q <= 1'b0;
         doneRdata_q <= '0;
         doneErr_q   <= ERR_NONE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         size_q      <= SIZE_B;
         uns_q       <= 1'b0;
         addrLo_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         opReady_q   <= opReady_d;
         reqValid_q  <= reqValid_d;
         reqAddr_q   <= reqAddr_d;
         reqData_q   <= reqData_d;
         reqMask_q   <= reqMask_d;
         doneValid_q <= doneValid_d;
         doneRdata_q <= doneRdata_d;
         doneErr_q   <= doneErr_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         addrLo_q    <= addrLo_d;
      end
   end

   // Next-state logic; a response on the expiry cycle takes priority over
   // the timeout so a late-but-valid answer is never thrown away.
   always_comb begin
      state_d     = state_q;
      reqValid_d  = reqValid_q;
      reqAddr_d   = reqAddr_q;
      reqData_d   = reqData_q;
      reqMask_d   = reqMask_q;
      doneValid_d = 1'b0;
      doneRdata_d = '0;
      doneErr_d   = ERR_NONE;
      cnt_d       = cnt_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addrLo_d    = addrLo_q;
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               we_d     = op_we;
               size_d   = op_size;
               uns_d    = op_unsigned;
               addrLo_d = op_addr[1:0];
               cnt_d    = '0;
               if (isMisaligned(op_size, op_addr[1:0])) begin
                  state_d     = DONE;
                  doneValid_d = 1'b1;
                  doneErr_d   = ERR_ALIGN;
               end else begin
                  state_d    = REQ;
                  reqValid_d = 1'b1;
                  reqAddr_d  = {op_addr[WIDTH-1:2], 2'b00};
                  reqData_d  = op_we ? alignWdata : '0;
                  reqMask_d  = op_we ? alignMask  : '0;
               end
            end
         end
         REQ: begin
            if (resp_valid) begin
               state_d     = DONE;
               reqValid_d  = 1'b0;
               doneValid_d = 1'b1;
               doneErr_d   = ERR_NONE;
               doneRdata_d = we_q ? '0 : alignRdata;
            end else if (cnt_q + 8'd1 == TMAX) begin
               state_d     = DONE;
               reqValid_d  = 1'b0;
               doneValid_d = 1'b1;
               doneErr_d   = ERR_TIMEOUT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      opReady_d = (state_d == IDLE);
   end

   assign op_ready   = opReady_q;
   assign req_valid  = reqValid_q;
   assign req_addr   = reqAddr_q;
   assign req_data   = reqData_q;
   assign req_mask   = reqMask_q;
   assign done_valid = doneValid_q;
   assign done_rdata = doneRdata_q;
   assign done_err   = doneErr_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a short timeout so expiry is quick.
module tb_mem_req_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid, op_ready, op_we, op_unsigned;
   logic [1:0]  op_size;
   logic [31:0] op_addr, op_wdata;
   logic        done_valid;
   logic [31:0] done_rdata;
   logic [1:0]  done_err;
   logic        req_valid;
   logic [31:0] req_addr, req_data;
   logic [3:0]  req_mask;
   logic        resp_valid;
   logic [31:0] resp_data;

   int vectors     = 0;
   int miscompares = 0;

   mem_req_master #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_we       (op_we),
      .op_size     (op_size),
      .op_unsigned (op_unsigned),
      .op_addr     (op_addr),
      .op_wdata    (op_wdata),
      .done_valid  (done_valid),
      .done_rdata  (done_rdata),
      .done_err    (done_err),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_mask    (req_mask),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present one op for a single accept edge; returns on the negedge after it.
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
      op_valid    = 1'b1;
      op_we       = we;
      op_size     = size;
      op_unsigned = uns;
      op_addr     = addr;
      op_wdata    = wdata;
      @(negedge clk);
      op_valid    = 1'b0;
   endtask

   // Pulse resp_valid for one edge; returns on the negedge after it.
   task automatic respond(input logic [31:0] data);
      resp_valid = 1'b1;
      resp_data  = data;
      @(negedge clk);
      resp_valid = 1'b0;
   endtask

   // Pass a completed op through its finishing DONE cycle back into IDLE.
   task automatic finishOp();
      @(negedge clk);
      checkOutput("back_idle_ready", 32'(op_ready), 32'd1);
      checkOutput("back_idle_done", 32'(done_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
      op_addr = '0; op_wdata = '0; resp_valid = 1'b0; resp_data = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_ready", 32'(op_ready), 32'd1);
      checkOutput("rst_req_valid", 32'(req_valid), 32'd0);
      checkOutput("rst_done_valid", 32'(done_valid), 32'd0);
      checkOutput("rst_done_rdata", done_rdata, 32'h0);
      checkOutput("rst_req_mask", 32'(req_mask), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Load word, one-cycle response
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      checkOutput("lw_req_valid", 32'(req_valid), 32'd1);
      checkOutput("lw_req_addr", req_addr, 32'h10);
      checkOutput("lw_req_mask", 32'(req_mask), 32'h0);
      checkOutput("lw_busy", 32'(op_ready), 32'd0);
      respond(32'hDEADBEEF);
      checkOutput("lw_done_valid", 32'(done_valid), 32'd1);
      checkOutput("lw_rdata", done_rdata, 32'hDEADBEEF);
      checkOutput("lw_err", 32'(done_err), 32'd0);
      checkOutput("lw_req_drop", 32'(req_valid), 32'd0);
      finishOp();

      // Byte/half extraction from 0x80FF7F01
      applyStimulus(1'b0, 2'd0, 1'b0, 32'h3, 32'h0);
      respond(32'h80FF7F01);
      checkOutput("lb3_rdata", done_rdata, 32'hFFFFFF80);
      finishOp();
      applyStimulus(1'b0, 2'd0, 1'b1, 32'h3, 32'h0);
      respond(32'h80FF7F01);
      checkOutput("lbu3_rdata", done_rdata, 32'h00000080);
      finishOp();
      applyStimulus(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
      respond(32'h80FF7F01);
      checkOutput("lh2_rdata", done_rdata, 32'hFFFF80FF);
      finishOp();
      applyStimulus(1'b0, 2'd0, 1'b0, 32'h1, 32'h0);
      respond(32'h80FF7F01);
      checkOutput("lb1_rdata", done_rdata, 32'h0000007F);
      finishOp();
      applyStimulus(1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
      respond(32'h80FF7F01);
      checkOutput("lhu0_rdata", done_rdata, 32'h00007F01);
      finishOp();

      // Stores: lane placement and zero completion data
      applyStimulus(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000ABCD);
      checkOutput("sh_req_addr", req_addr, 32'h4);
      checkOutput("sh_req_mask", 32'(req_mask), 32'hC);
      checkOutput("sh_req_data", req_data, 32'hABCD0000);
      respond(32'h11111111);
      checkOutput("sh_done_valid", 32'(done_valid), 32'd1);
      checkOutput("sh_rdata", done_rdata, 32'h0);
      finishOp();
      applyStimulus(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000012);
      checkOutput("sb_req_addr", req_addr, 32'h20);
      checkOutput("sb_req_mask", 32'(req_mask), 32'h2);
      checkOutput("sb_req_data", req_data, 32'h00001200);
      respond(32'h0);
      finishOp();
      applyStimulus(1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFEF00D);
      checkOutput("sw_req_mask", 32'(req_mask), 32'hF);
      checkOutput("sw_req_data", req_data, 32'hCAFEF00D);
      respond(32'h0);
      finishOp();

      // Alignment errors: no request, immediate completion
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
      checkOutput("mis_lw_req_valid", 32'(req_valid), 32'd0);
      checkOutput("mis_lw_done", 32'(done_valid), 32'd1);
      checkOutput("mis_lw_err", 32'(done_err), 32'd1);
      finishOp();
      applyStimulus(1'b0, 2'd1, 1'b0, 32'h1, 32'h0);
      checkOutput("mis_lh_err", 32'(done_err), 32'd1);
      finishOp();
      applyStimulus(1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
      checkOutput("ill_size_err", 32'(done_err), 32'd1);
      checkOutput("ill_size_req", 32'(req_valid), 32'd0);
      finishOp();

      // Timeout: four REQ cycles, then error, late response ignored
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("to_req_held", 32'(req_valid), 32'd1);
         @(negedge clk);
      end
      checkOutput("to_req_last", 32'(req_valid), 32'd1);
      @(negedge clk);
      checkOutput("to_req_drop", 32'(req_valid), 32'd0);
      checkOutput("to_done", 32'(done_valid), 32'd1);
      checkOutput("to_err", 32'(done_err), 32'd2);
      checkOutput("to_rdata", done_rdata, 32'h0);
      finishOp();
      respond(32'h55555555);
      checkOutput("to_late_resp", 32'(done_valid), 32'd0);
      @(negedge clk);
      checkOutput("to_late_resp2", 32'(done_valid), 32'd0);

      // Response on the expiry cycle wins over the timeout
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      respond(32'h0BADCAFE);
      checkOutput("exp_done", 32'(done_valid), 32'd1);
      checkOutput("exp_err", 32'(done_err), 32'd0);
      checkOutput("exp_rdata", done_rdata, 32'h0BADCAFE);
      finishOp();

      // Reset in the middle of a request
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
      checkOutput("rmid_req_valid", 32'(req_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rmid_req_valid0", 32'(req_valid), 32'd0);
      checkOutput("rmid_req_addr0", req_addr, 32'h0);
      checkOutput("rmid_done0", 32'(done_valid), 32'd0);
      checkOutput("rmid_ready", 32'(op_ready), 32'd1);
      rst = 1'b0;
      respond(32'h99999999);
      checkOutput("rmid_stale_resp", 32'(done_valid), 32'd0);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
      checkOutput("rmid_lw_addr", req_addr, 32'h0);
      respond(32'h12345678);
      checkOutput("rmid_lw_done", 32'(done_valid), 32'd1);
      checkOutput("rmid_lw_rdata", done_rdata, 32'h12345678);
      finishOp();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
